// File: rtl/gate_pkg.sv
// Shared types and width helpers for the gate-cell receive path.
// Widths derive from the WIDTH/DEPTH parameters of each instance.
package gate_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_e;

   localparam int WIDTH_DEF = 8;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W     = $clog2(WIDTH_DEF);
   localparam int LVL_W     = $clog2(DEPTH_DEF) + 1;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/gate_result_collector_if.sv
// Bundle between the serial gate stream, the collector and the readout logic.
// The master drives the bit stream and the readout controls; the slave is the collector.
interface gate_result_collector_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic                     en_in;
   logic                     in_bit;
   logic                     word_ready;
   logic                     clr_ovf;
   logic [WIDTH-1:0]         word_out;
   logic                     word_valid;
   logic [$clog2(DEPTH):0]   fill_level;
   logic                     overflow;
   logic                     frame_err;

   modport master (
      output en_in, in_bit, word_ready, clr_ovf,
      input  word_out, word_valid, fill_level, overflow, frame_err
   );

   modport slave (
      input  en_in, in_bit, word_ready, clr_ovf,
      output word_out, word_valid, fill_level, overflow, frame_err
   );
endinterface

// File: rtl/gate_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into a full FIFO
// only succeeds when a pop happens on the same edge.
module gate_sync_fifo
   import gate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      pop,
   output logic [WIDTH-1:0]          rdata,
   output logic [lvl_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LW    = lvl_w(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             push_ok, pop_ok;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == FULL_LVL);
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
      // The slot being written this edge can already be the next head.
      head_d = '0;
      if (count_d != '0)
         head_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? wdata : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign rdata = head_q;
   assign count = count_q;
endmodule

// File: rtl/gate_result_collector.sv
// Receive end of the gate-cell stream: packs serial bits LSB-first into words,
// queues them for readout and flags timeouts inside a word and dropped words.
module gate_result_collector
   import gate_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input logic                    clk,
   input logic                    rst,
   gate_result_collector_if.slave bus
);
   localparam int CW = cnt_w(WIDTH);
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic [WIDTH-2:0]       shift_q, shift_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overflow_q, overflow_d;
   logic                   push, pop;
   logic [WIDTH-1:0]       push_word;
   logic                   fifo_full, fifo_empty;
   logic [lvl_w(DEPTH)-1:0] fifo_count;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      push_word   = {bus.in_bit, shift_q};
      case (state_q)
         IDLE: begin
            if (bus.en_in) begin
               shift_d[0] = bus.in_bit;
               bit_cnt_d  = CW'(1);
               idle_cnt_d = '0;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            // A bit on the would-be timeout cycle is accepted, not an error.
            if (bus.en_in) begin
               idle_cnt_d = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  push      = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  shift_d[bit_cnt_q] = bus.in_bit;
                  bit_cnt_d          = bit_cnt_q + 1'b1;
               end
            end else if (idle_cnt_q == IDLE_LAST) begin
               frame_err_d = 1'b1;
               bit_cnt_d   = '0;
               idle_cnt_d  = '0;
               state_d     = IDLE;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      pop = !fifo_empty && bus.word_ready;
      // A drop on the clearing edge keeps the flag set.
      if (push && fifo_full && !pop) overflow_d = 1'b1;
      else if (bus.clr_ovf)          overflow_d = 1'b0;
      else                           overflow_d = overflow_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   gate_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (push_word),
      .pop   (bus.word_ready),
      .rdata (bus.word_out),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.word_valid = !fifo_empty;
   assign bus.fill_level = fifo_count;
   assign bus.overflow   = overflow_q;
   assign bus.frame_err  = frame_err_q;
endmodule
